// File: rtl/regfile_dbg_if.sv
// Debug dump stream: one register per beat, valid/ready handshake.
// The master holds idx/data stable while valid && !ready.
interface regfile_dbg_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             dbg_valid;
  logic             dbg_ready;
  logic [AW-1:0]    dbg_idx;
  logic [WIDTH-1:0] dbg_data;

  modport master (output dbg_valid, output dbg_idx, output dbg_data, input dbg_ready);
  modport slave  (input dbg_valid, input dbg_idx, input dbg_data, output dbg_ready);
endinterface

// File: rtl/regfile_dbg.sv
// Register file (1-cycle write, combinational reads, optional bypass) with a debug dump engine.
// Dump streams NREGS beats back-to-back under ready; beats stall in place while ready is low.
module regfile_dbg #(
  parameter int WIDTH  = 16,
  parameter int AW     = 3,
  parameter int NRD    = 2,
  parameter int BYPASS = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic [AW-1:0]        writenum,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [NRD*AW-1:0]    readnum,
  output logic [NRD*WIDTH-1:0] data_out,
  input  logic                 dbg_start,
  regfile_dbg_if.master        dbg,
  output logic                 dbg_busy,
  output logic                 dbg_done
);
  localparam int NREGS = 1 << AW;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_beat;

  // regs_d[i] is the value R[i] holds after this edge, which is exactly what a captured beat must show
  always_comb begin
    regs_d = regs_q;
    if (write) regs_d[writenum] = data_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] rd_idx;
    assign rd_idx = readnum[k*AW +: AW];
    assign data_out[k*WIDTH +: WIDTH] =
      ((BYPASS != 0) && write && (writenum == rd_idx)) ? data_in : regs_q[rd_idx];
  end

  assign last_beat = (idx_q == AW'(NREGS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (dbg_start) begin
          state_d = SEND;
          idx_d   = '0;
          data_d  = regs_d[0];
        end
      end
      SEND: begin
        if (dbg.dbg_ready) begin
          if (last_beat) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + AW'(1);
            data_d = regs_d[idx_q + AW'(1)];
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dbg.dbg_valid = (state_q == SEND);
    dbg.dbg_idx   = idx_q;
    dbg.dbg_data  = data_q;
    dbg_busy      = (state_q == SEND) || (state_q == DONE);
    dbg_done      = (state_q == DONE);
  end
endmodule
